// File: rtl/divisor_8bits.sv
// Multi-cycle 8-bit unsigned restoring divider with a 7-bit saturating quotient.
// A request in IDLE either runs 8 CALC steps or, for a zero divisor, reports an error at once.
module divisor_8bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] D,
    output logic [6:0] A_div,
    output logic [7:0] R,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] d_q, d_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] quo_q, quo_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] a_div_q, a_div_d;
    logic [7:0] r_q, r_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [8:0] shifted;
    logic       step_bit;
    logic [7:0] step_rem;
    logic [7:0] quo_next;

    // The quotient only overflows 7 bits when dividing a value >= 128 by one.
    function automatic logic [15:0] finalize(input logic [7:0] quo, input logic [7:0] rem);
        if (quo > 8'd127)
            finalize = {1'b1, 7'h7F, 8'h00};
        else
            finalize = {1'b0, quo[6:0], rem};
    endfunction

    always_comb begin
        // One restoring step: the shifted remainder needs 9 bits, the difference fits in 8.
        shifted  = {rem_q, a_q[7]};
        step_bit = (shifted >= {1'b0, d_q});
        step_rem = step_bit ? (shifted[7:0] - d_q) : shifted[7:0];
        quo_next = {quo_q[6:0], step_bit};

        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        a_div_d = a_div_q;
        r_d     = r_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (D == 8'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        a_div_d = 7'h7F;
                        r_d     = A;
                    end else begin
                        state_d = CALC;
                        a_d     = A;
                        d_d     = D;
                        rem_d   = 8'd0;
                        quo_d   = 8'd0;
                        cnt_d   = 3'd0;
                    end
                end
            end
            CALC: begin
                a_d   = {a_q[6:0], 1'b0};
                rem_d = step_rem;
                quo_d = quo_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    {err_d, a_div_d, r_d} = finalize(quo_next, step_rem);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'd0;
            d_q     <= 8'd0;
            rem_q   <= 8'd0;
            quo_q   <= 8'd0;
            cnt_q   <= 3'd0;
            a_div_q <= 7'd0;
            r_q     <= 8'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            a_div_q <= a_div_d;
            r_q     <= r_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A_div = a_div_q;
    assign R     = r_q;
    assign err   = err_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_divisor_8bits.sv
// Randomised and directed bench for divisor_8bits, checked against an arithmetic model of A/D and A%D.
module tb_divisor_8bits;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] A = 8'd0;
    logic [7:0] D = 8'd0;
    logic [6:0] A_div;
    logic [7:0] R;
    logic       busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    divisor_8bits dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .D(D),
        .A_div(A_div), .R(R), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Expected {err, A_div, R} straight from integer division and the saturation/error rules.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] d);
        int q;
        if (d == 8'd0) return {1'b1, 7'h7F, a};
        q = int'(a) / int'(d);
        if (q > 127) return {1'b1, 7'h7F, 8'h00};
        return {1'b0, q[6:0], 8'(int'(a) % int'(d))};
    endfunction

    // Edges are counted with the start edge as edge 1; result is captured when done is seen.
    task automatic do_op(input logic [7:0] a, input logic [7:0] d,
                         output int edges, output logic [15:0] res, output logic post_ok);
        @(negedge clk);
        A = a; D = d; start = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        start = 1'b0;
        A = 8'($urandom); D = 8'($urandom);
        while (!done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        res = {err, A_div, R};
        @(posedge clk); #1;
        post_ok = !done && !busy && ({err, A_div, R} == res);
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({A_div, R, err, done, busy} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state: got A_div=%0d R=%0d err=%b done=%b busy=%b, want all 0",
                     A_div, R, err, done, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] av[6] = '{8'd200, 8'd255, 8'd100, 8'd50, 8'd200, 8'd90};
        logic [7:0] dv[6] = '{8'd2, 8'd2, 8'd7, 8'd0, 8'd1, 8'd1};
        logic [15:0] want[6] = '{{1'b0, 7'd100, 8'd0}, {1'b0, 7'd127, 8'd1}, {1'b0, 7'd14, 8'd2},
                                 {1'b1, 7'd127, 8'd50}, {1'b1, 7'd127, 8'd0}, {1'b0, 7'd90, 8'd0}};
        int  wedges[6] = '{9, 9, 9, 1, 9, 9};
        int edges;
        logic [15:0] res;
        logic ok;
        for (int i = 0; i < 6; i++) begin
            do_op(av[i], dv[i], edges, res, ok);
            n_tests++;
            if (res !== want[i] || edges != wedges[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got err=%b q=%0d r=%0d edges=%0d, want err=%b q=%0d r=%0d edges=%0d",
                         i, res[15], res[14:8], res[7:0], edges, want[i][15], want[i][14:8], want[i][7:0], wedges[i]);
            end
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL directed_hold_%0d: outputs not held or done/busy not cleared after done", i);
            end
        end
    endtask

    task automatic test_div_by_two();
        int edges;
        logic [15:0] res;
        logic ok;
        logic [7:0] a;
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom);
            do_op(a, 8'd2, edges, res, ok);
            n_tests++;
            if (res !== {1'b0, a[7:1], 7'd0, a[0]}) begin
                n_fail++;
                $display("FAIL div2 A=%0d: got q=%0d r=%0d err=%b, want q=%0d r=%0d err=0",
                         a, res[14:8], res[7:0], res[15], a[7:1], a[0]);
            end
        end
    endtask

    task automatic test_restart_during_calc();
        int pulses = 0;
        logic [15:0] res = 16'hFFFF;
        @(negedge clk);
        A = 8'd100; D = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        A = 8'd50; D = 8'd3; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                res = {err, A_div, R};
            end
        end
        n_tests++;
        if (pulses != 1 || res !== {1'b0, 7'd14, 8'd2}) begin
            n_fail++;
            $display("FAIL restart_in_calc: got pulses=%0d q=%0d r=%0d err=%b, want pulses=1 q=14 r=2 err=0",
                     pulses, res[14:8], res[7:0], res[15]);
        end
    endtask

    task automatic test_start_at_done();
        int guard = 0;
        @(negedge clk);
        A = 8'd60; D = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        // Start raised while done is high: the DONE state must not take it.
        start = 1'b1; A = 8'd9; D = 8'd0;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || {err, A_div, R} !== {1'b0, 7'd12, 8'd0}) begin
            n_fail++;
            $display("FAIL start_at_done: got busy=%b done=%b q=%0d r=%0d err=%b, want busy=0 done=0 q=12 r=0 err=0",
                     busy, done, A_div, R, err);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if (done !== 1'b1 || {err, A_div, R} !== {1'b1, 7'h7F, 8'd9}) begin
            n_fail++;
            $display("FAIL start_after_done: got done=%b q=%0d r=%0d err=%b, want done=1 q=127 r=9 err=1",
                     done, A_div, R, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int pulses = 0;
        int edges;
        logic [15:0] res;
        logic ok;
        @(negedge clk);
        A = 8'd100; D = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({A_div, R, err, done, busy} !== 19'd0) begin
            n_fail++;
            $display("FAIL abort_reset: got A_div=%0d R=%0d err=%b done=%b busy=%b, want all 0",
                     A_div, R, err, done, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d cycles with done/busy, want 0", pulses);
        end
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        do_op(8'd77, 8'd10, edges, res, ok);
        n_tests++;
        if (res !== {1'b0, 7'd7, 8'd7} || edges != 9) begin
            n_fail++;
            $display("FAIL first_edge_after_reset: got q=%0d r=%0d err=%b edges=%0d, want q=7 r=7 err=0 edges=9",
                     res[14:8], res[7:0], res[15], edges);
        end
    endtask

    task automatic test_random();
        int edges;
        int wedges;
        logic [15:0] res, want;
        logic ok;
        logic [7:0] a, d;
        int sel;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 9);
            d = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : 8'($urandom_range(1, 255));
            want = model(a, d);
            wedges = (d == 8'd0) ? 1 : 9;
            do_op(a, d, edges, res, ok);
            n_tests++;
            if (res !== want || edges != wedges || !ok) begin
                n_fail++;
                $display("FAIL random A=%0d D=%0d: got err=%b q=%0d r=%0d edges=%0d hold=%b, want err=%b q=%0d r=%0d edges=%0d hold=1",
                         a, d, res[15], res[14:8], res[7:0], edges, ok, want[15], want[14:8], want[7:0], wedges);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_two();
        test_restart_during_calc();
        test_start_at_done();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
